dcp_print: RTL and testbench



---
 rtl/dcp_print.sv | 179 +++++++++++++++++
 tb/tb_dcp_print.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/dcp_print.sv
// dcp_print: DCP transmit formatter, raw byte or uppercase hex plus suffix onto UART TX.
// Optional build macro DCP_PRINT_ZERO_SUPPRESS_EN skips leading zero hex digits.
module dcp_print #(
    parameter int HEX_DIGITS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_tx,
    input  logic        type_tx,
    input  logic [1:0]  suffix_tx,
    input  logic [31:0] din_tx,
    output logic        busy_tx,
    output logic        ack_tx,
    output logic [7:0]  d_tx,
    output logic        vld_tx,
    input  logic        rdy_tx
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND   = 2'd1,
        SUFFIX = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [2:0] TOP = 3'(HEX_DIGITS - 1);

    state_t      state, state_n;
    logic [31:0] data, data_n;
    logic        typ, typ_n;
    logic [1:0]  sfx, sfx_n;
    logic [2:0]  cnt, cnt_n;
    logic        sidx, sidx_n;
    logic [7:0]  d_n;
    logic        vld_n;
    logic        ack_n;
    logic        busy_n;
    logic        xfer;
    logic [2:0]  top_idx;

    function automatic logic [3:0] nib(input logic [31:0] v,
                                       input logic [2:0]  i);
        return v[{i, 2'b00} +: 4];
    endfunction

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? {4'h3, n} : 8'h37 + {4'h0, n};
    endfunction

    // Index of the first digit to print for a freshly requested value.
`ifdef DCP_PRINT_ZERO_SUPPRESS_EN
    always_comb begin
        top_idx = 3'd0;
        for (int i = 0; i < HEX_DIGITS; i++) begin
            if (din_tx[i*4 +: 4] != 4'h0) top_idx = 3'(i);
        end
    end
`else
    always_comb begin
        top_idx = TOP;
    end
`endif

    assign xfer = vld_tx && rdy_tx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            data    <= '0;
            typ     <= 1'b0;
            sfx     <= 2'b00;
            cnt     <= 3'd0;
            sidx    <= 1'b0;
            d_tx    <= 8'h00;
            vld_tx  <= 1'b0;
            ack_tx  <= 1'b0;
            busy_tx <= 1'b0;
        end else begin
            state   <= state_n;
            data    <= data_n;
            typ     <= typ_n;
            sfx     <= sfx_n;
            cnt     <= cnt_n;
            sidx    <= sidx_n;
            d_tx    <= d_n;
            vld_tx  <= vld_n;
            ack_tx  <= ack_n;
            busy_tx <= busy_n;
        end
    end

    always_comb begin
        state_n = state;
        data_n  = data;
        typ_n   = typ;
        sfx_n   = sfx;
        cnt_n   = cnt;
        sidx_n  = sidx;
        d_n     = d_tx;
        vld_n   = vld_tx;
        ack_n   = 1'b0;
        busy_n  = busy_tx;

        unique case (state)
            IDLE: begin
                busy_n = 1'b0;
                vld_n  = 1'b0;
                if (req_tx) begin
                    data_n  = din_tx;
                    typ_n   = type_tx;
                    sfx_n   = suffix_tx;
                    sidx_n  = 1'b0;
                    busy_n  = 1'b1;
                    vld_n   = 1'b1;
                    state_n = SEND;
                    if (type_tx) begin
                        cnt_n = top_idx;
                        d_n   = hex_char(nib(din_tx, top_idx));
                    end else begin
                        cnt_n = 3'd0;
                        d_n   = din_tx[7:0];
                    end
                end
            end

            SEND: begin
                if (xfer) begin
                    if (!typ || cnt == 3'd0) begin
                        // Suffix byte follows the last digit with no vld gap.
                        unique case (1'b1)
                            (sfx == 2'b01): begin
                                state_n = SUFFIX;
                                d_n     = 8'h20;
                            end
                            (sfx == 2'b10): begin
                                state_n = SUFFIX;
                                d_n     = 8'h0D;
                            end
                            default: begin
                                state_n = DONE;
                                vld_n   = 1'b0;
                                ack_n   = 1'b1;
                            end
                        endcase
                    end else begin
                        cnt_n = cnt - 3'd1;
                        d_n   = hex_char(nib(data, cnt - 3'd1));
                    end
                end
            end

            SUFFIX: begin
                if (xfer) begin
                    if (sfx == 2'b10 && !sidx) begin
                        sidx_n = 1'b1;
                        d_n    = 8'h0A;
                    end else begin
                        state_n = DONE;
                        vld_n   = 1'b0;
                        ack_n   = 1'b1;
                    end
                end
            end

            DONE: begin
                state_n = IDLE;
                busy_n  = 1'b0;
                vld_n   = 1'b0;
            end

            default: begin
                state_n = IDLE;
                busy_n  = 1'b0;
                vld_n   = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_dcp_print.sv
// Directed self-checking bench for dcp_print.
// Expected strings are hand-written per test case.
module tb_dcp_print;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_tx = 1'b0;
    logic        type_tx = 1'b0;
    logic [1:0]  suffix_tx = 2'b00;
    logic [31:0] din_tx = '0;
    logic        busy_tx;
    logic        ack_tx;
    logic [7:0]  d_tx;
    logic        vld_tx;
    logic        rdy_tx;

    logic        rnd = 1'b0;
    int          pass_cnt = 0;
    int          chk_cnt = 0;
    int          ack_cnt = 0;
    logic [7:0]  q[$];
    logic        stall_p = 1'b0;
    logic [7:0]  stall_d = 8'h00;

    dcp_print #(.HEX_DIGITS(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_tx    (req_tx),
        .type_tx   (type_tx),
        .suffix_tx (suffix_tx),
        .din_tx    (din_tx),
        .busy_tx   (busy_tx),
        .ack_tx    (ack_tx),
        .d_tx      (d_tx),
        .vld_tx    (vld_tx),
        .rdy_tx    (rdy_tx)
    );

    always #5 clk = ~clk;

    initial rdy_tx = 1'b1;
    always @(posedge clk) begin
        #1;
        rdy_tx = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Byte capture, stall stability and ack counting.
    always @(negedge clk) begin
        if (rst) begin
            stall_p = 1'b0;
        end else begin
            if (stall_p) begin
                check("stall_vld", {31'd0, vld_tx}, 32'd1);
                check("stall_d", {24'd0, d_tx}, {24'd0, stall_d});
            end
            stall_p = vld_tx && !rdy_tx;
            stall_d = d_tx;
            if (vld_tx && rdy_tx) q.push_back(d_tx);
            if (ack_tx) ack_cnt++;
        end
    end

    function automatic bq_t s2q(input string s);
        bq_t r;
        for (int i = 0; i < s.len(); i++) r.push_back(s[i]);
        return r;
    endfunction

    task automatic check_bytes(input string tag, input int base,
                               input bq_t e);
        check({tag, "_len"}, q.size() - base, e.size());
        for (int i = 0; i < e.size(); i++) begin
            if (base + i < q.size())
                check($sformatf("%s_b%0d", tag, i), {24'd0, q[base+i]},
                      {24'd0, e[i]});
        end
    endtask

    task automatic start(input logic t, input logic [1:0] s,
                         input logic [31:0] d);
        @(posedge clk);
        #1;
        req_tx = 1'b1;
        type_tx = t;
        suffix_tx = s;
        din_tx = d;
        @(posedge clk);
        #1;
        req_tx = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ack_tx && n < 300);
        check({tag, "_ack"}, {31'd0, ack_tx}, 32'd1);
        @(negedge clk);
        check({tag, "_busy_low"}, {31'd0, busy_tx}, 32'd0);
        check({tag, "_ack_low"}, {31'd0, ack_tx}, 32'd0);
    endtask

    task automatic run(input string tag, input logic t, input logic [1:0] s,
                       input logic [31:0] d, input bq_t e);
        int b;
        int a;
        b = q.size();
        a = ack_cnt;
        start(t, s, d);
        wait_done(tag);
        check_bytes(tag, b, e);
        check({tag, "_acks"}, ack_cnt - a, 32'd1);
    endtask

    initial begin
        int b;
        int a;
        int n;
        bq_t e;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_vld", {31'd0, vld_tx}, 32'd0);
        check("rst_d", {24'd0, d_tx}, 32'd0);
        check("rst_ack", {31'd0, ack_tx}, 32'd0);
        check("rst_busy", {31'd0, busy_tx}, 32'd0);

        // Back-to-back hex with exact cycle timing.
        b = q.size();
        a = ack_cnt;
        start(1'b1, 2'b00, 32'h1234ABCD);
        e = s2q("1234ABCD");
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("t1_vld%0d", i), {31'd0, vld_tx}, 32'd1);
            check($sformatf("t1_d%0d", i), {24'd0, d_tx}, {24'd0, e[i]});
            check($sformatf("t1_busy%0d", i), {31'd0, busy_tx}, 32'd1);
        end
        @(negedge clk);
        check("t1_ack", {31'd0, ack_tx}, 32'd1);
        check("t1_ack_vld", {31'd0, vld_tx}, 32'd0);
        check("t1_ack_busy", {31'd0, busy_tx}, 32'd1);
        @(negedge clk);
        check("t1_ack_off", {31'd0, ack_tx}, 32'd0);
        check("t1_busy_off", {31'd0, busy_tx}, 32'd0);
        check_bytes("t1", b, e);
        check("t1_acks", ack_cnt - a, 32'd1);

        run("char_crlf", 1'b0, 2'b10, 32'h00000050,
            '{8'h50, 8'h0D, 8'h0A});
        run("char_none3", 1'b0, 2'b11, 32'hFFFFFF41, '{8'h41});

        rnd = 1'b1;
        run("rand_sp", 1'b1, 2'b01, 32'hDEADBEEF, s2q("DEADBEEF "));
        run("rand_crlf", 1'b1, 2'b10, 32'h0F1E2D3C,
            '{8'h30, 8'h46, 8'h31, 8'h45, 8'h32, 8'h44, 8'h33, 8'h43,
              8'h0D, 8'h0A});
        rnd = 1'b0;

        // Request while busy is ignored.
        b = q.size();
        a = ack_cnt;
        start(1'b1, 2'b00, 32'h00000001);
        @(posedge clk);
        #1;
        req_tx = 1'b1;
        din_tx = 32'hFFFFFFFF;
        suffix_tx = 2'b10;
        @(posedge clk);
        #1;
        req_tx = 1'b0;
        wait_done("busy_req");
        repeat (15) @(negedge clk);
        check_bytes("busy_req", b, s2q("00000001"));
        check("busy_req_acks", ack_cnt - a, 32'd1);

        // Reset in the middle of a hex print.
        a = ack_cnt;
        b = q.size();
        start(1'b1, 2'b00, 32'h12345678);
        n = 0;
        while (q.size() - b < 3 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("mid_rst_3bytes", q.size() - b, 32'd3);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_vld", {31'd0, vld_tx}, 32'd0);
        check("mid_rst_ack", {31'd0, ack_tx}, 32'd0);
        check("mid_rst_busy", {31'd0, busy_tx}, 32'd0);
        repeat (5) @(negedge clk);
        check("mid_rst_noack", ack_cnt - a, 32'd0);
        run("after_rst", 1'b1, 2'b00, 32'h0000000A, s2q("0000000A"));

`ifdef DCP_PRINT_ZERO_SUPPRESS_EN
        run("zs_f", 1'b1, 2'b00, 32'h0000000F, s2q("F"));
        run("zs_0", 1'b1, 2'b01, 32'h00000000, s2q("0 "));
        run("zs_top", 1'b1, 2'b00, 32'h10000000, s2q("10000000"));
        run("zs_char", 1'b0, 2'b00, 32'h00000000, '{8'h00});
`else
        run("nz_f", 1'b1, 2'b00, 32'h0000000F, s2q("0000000F"));
        run("nz_0", 1'b1, 2'b01, 32'h00000000, s2q("00000000 "));
        run("nz_top", 1'b1, 2'b00, 32'h10000000, s2q("10000000"));
`endif

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
